fifo_wr_arbiter: RTL and testbench
==================================

# fifo_wr_arbiter

Round-robin, credit-based write-side arbiter that shares one `fifo_depth8_asy` write port among four requesters in the write clock domain. It grants bursts of up to `max_burst` words to one requester at a time and registers the selected word onto the FIFO write port. It tracks free FIFO entries with a local credit counter, so the one-cycle lag of the FIFO's registered full flag can never cause an overwrite.

## Interface
- `bw`, 4, bits per SIMD lane (matches FIFO)
- `simd`, 1, lanes per word (matches FIFO)
- `depth`, 8, FIFO entries; also the credit reset value
- `max_burst`, 4, maximum words per grant (1..8)

- `clk`  in  1  write-domain clock; same net as FIFO `wr_clk`
- `rst_n`  in  1  asynchronous, active-low reset. FIFO `wr_rst` is driven from `~rst_n`.
- `req_valid`  in  4  requester i holds a word
- `req_data`  in  4*simd*bw  requester i word at `[i*simd*bw +: simd*bw]`
- `req_ready`  out  4  one-hot; word i is accepted at a rising edge when `req_valid[i] & req_ready[i]`
- `fifo_wr`  out  1  registered write strobe to FIFO `wr`
- `fifo_in`  out  simd*bw  registered write data to FIFO `in`
- `fifo_full`  in  1  FIFO `o_full`
- `crd_ret`  in  1  one-cycle pulse per FIFO pop, already synchronized into `clk`
- `grant_id`  out  2  index of the current/last granted requester
- `credits`  out  4  free entries not yet committed (0..depth)
- `crd_err`  out  1  sticky; set by a credit return while `credits==depth`

## Operation
- States: IDLE, BURST. Internal registers: `gnt[1:0]`, `last[1:0]`, `beat_cnt`.
- IDLE: if any `req_valid` is high, the winner is the first set bit searching `last+1, last+2, …` (mod 4). Next state is BURST, `gnt`=winner, `grant_id`=winner, `beat_cnt`=0. No grant is issued while in IDLE.
- `req_ready[i]` = (state==BURST) & (gnt==i) & (credits!=0) & ~fifo_full. It is derived only from registers and `fifo_full`. It has no combinational path from `req_valid`.
- Beat (handshake at edge):
  - `fifo_wr`<=1 and `fifo_in`<=word of `gnt`.
  - `beat_cnt`++.
  - Credits decrement by 1.
- No beat: `fifo_wr`<=0 and `fifo_in` holds its value.
- BURST exits to IDLE, with `last`<=gnt, on either condition:
  - a beat with `beat_cnt==max_burst-1`;
  - `req_valid[gnt]==0` at an edge, whether or not stalled.
- Stall on `credits==0` or `fifo_full`: remain in BURST indefinitely. No timeout.
- Credit update per edge: +`crd_ret` −beat. Simultaneous return and beat leaves credits unchanged.
- Saturation at `credits==depth`:
  - `crd_ret` without a beat leaves credits at `depth` and sets `crd_err`.
  - `crd_ret` with a beat gives a net change of 0 and no error.
- Credits never underflow, because no beat is possible at 0.
- Invariant: FIFO occupancy + `credits` ≤ `depth` at all times. This is conservative until returns arrive.
- Reset (asynchronous, any time, including mid-burst):
  - state IDLE, `last`=3 (requester 0 has first priority), `gnt`=0, `grant_id`=0, `beat_cnt`=0;
  - `credits`=`depth`, `fifo_wr`=0, `fifo_in`=0, `req_ready`=0, `crd_err`=0.
  - An in-flight registered word is discarded; the FIFO resets together with this block.

## Timing
- Arbitration bubble: 1 cycle. With IDLE and `req_valid` set in cycle 0:
  - `req_ready` is high in cycle 1;
  - the first beat occurs at the edge ending cycle 1;
  - `fifo_wr` is high in cycle 2.
- Beat-to-FIFO write latency: 1 cycle.
- Sustained throughput: `max_burst` words per `max_burst+1` cycles under continuous contention with credits available.
- `credits` updates at the same edge as the beat, i.e. one cycle before the FIFO pointer moves. This covers the FIFO's registered-full lag.
- `fifo_full` is a secondary gate only; credits alone prevent overflow.

## Test plan
- Single requester 0 streams 8 words with no returns. Required:
  - bursts 4+4 with one bubble between them;
  - `credits` 8→0;
  - `req_ready[0]` low after the 8th beat;
  - FIFO holds words 0..7 and none is overwritten.
- All four requesters continuously valid, `max_burst`=4, `crd_ret` every cycle. Required:
  - `grant_id` sequence 0,1,2,3,0;
  - each grant is exactly 4 beats;
  - `fifo_in` order matches the per-requester data.
- `credits`=0 with requester 2 stalled; pulse `crd_ret` once. Required: exactly one beat follows, credits 0→1→0, and the state stays BURST.
- Simultaneous `crd_ret` and beat at `credits`=3. Required: credits stay 3. Then `crd_ret` at `credits`=8 with no beat. Required: credits stay 8 and `crd_err` goes to 1 and stays 1.
- Requester 1 drops `req_valid` after 2 beats while requester 3 is waiting. Required: return to IDLE, `last`=1, and the next grant goes to 3.
- Assert `rst_n` low mid-burst with `credits`=5. Required, asynchronously:
  - `req_ready`=0, `fifo_wr`=0, `credits`=8, `grant_id`=0;
  - after release, requester 0 wins the first arbitration.

Source files
------------

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin, credit-based arbiter sharing one FIFO write port among four requesters.
// Grants bursts of up to max_burst words and registers the selected word onto the FIFO write port.
module fifo_wr_arbiter #(
    parameter int bw        = 4,
    parameter int simd      = 1,
    parameter int depth     = 8,
    parameter int max_burst = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [3:0]           req_valid,
    input  logic [4*simd*bw-1:0] req_data,
    output logic [3:0]           req_ready,
    output logic                 fifo_wr,
    output logic [simd*bw-1:0]   fifo_in,
    input  logic                 fifo_full,
    input  logic                 crd_ret,
    output logic [1:0]           grant_id,
    output logic [3:0]           credits,
    output logic                 crd_err
);
    localparam int ww = simd * bw;
    localparam int cw = $clog2(max_burst + 1);
    typedef enum logic {idle, burst} state_t;
    state_t        state, state_nx;
    logic [1:0]    gnt, gnt_nx, last, last_nx, winner;
    logic [cw-1:0] beat_cnt, beat_cnt_nx;
    logic [3:0]    credits_nx;
    logic          beat, done;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state    <= idle;
            gnt      <= 2'd0;
            last     <= 2'd3;
            beat_cnt <= '0;
        end else begin
            state    <= state_nx;
            gnt      <= gnt_nx;
            last     <= last_nx;
            beat_cnt <= beat_cnt_nx;
        end
    // Lowest k wins, so the search order is last+1, last+2, last+3, last.
    always_comb begin
        winner = last;
        for (int k = 4; k >= 1; k--)
            if (req_valid[last + 2'(k)]) winner = last + 2'(k);
    end
    assign beat = |(req_valid & req_ready);
    assign done = (beat && beat_cnt == cw'(max_burst - 1)) || !req_valid[gnt];
    always_comb begin
        state_nx    = state == idle ? (|req_valid ? burst : idle) : (done ? idle : burst);
        gnt_nx      = (state == idle && |req_valid) ? winner : gnt;
        last_nx     = (state == burst && done) ? gnt : last;
        beat_cnt_nx = state == idle ? '0 : beat_cnt + cw'(beat);
    end
    always_comb begin
        req_ready = (state == burst && credits != 4'd0 && !fifo_full) ? 4'b0001 << gnt : 4'b0000;
        grant_id  = gnt;
    end
    // A return at full credit saturates and flags the error unless a beat consumes it.
    always_comb
        credits_nx = (crd_ret && !beat) ? (credits == 4'(depth) ? credits : credits + 4'd1) :
                     (!crd_ret && beat) ? credits - 4'd1 : credits;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            credits <= 4'(depth);
            crd_err <= 1'b0;
            fifo_wr <= 1'b0;
            fifo_in <= '0;
        end else begin
            credits <= credits_nx;
            crd_err <= crd_err | (crd_ret & ~beat & (credits == 4'(depth)));
            fifo_wr <= beat;
            fifo_in <= beat ? req_data[gnt*ww +: ww] : fifo_in;
        end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: directed and randomized checks of fifo_wr_arbiter against a behavioural model.
module tb_fifo_wr_arbiter;
    localparam int depth = 8;
    localparam int mb    = 4;
    logic        clk = 0, rst_n = 1;
    logic [3:0]  req_valid = '0, req_ready;
    logic [15:0] req_data = '0;
    logic        fifo_wr, fifo_full = 0, crd_ret = 0, crd_err;
    logic [3:0]  fifo_in, credits;
    logic [1:0]  grant_id;
    int          n_vec = 0, n_err = 0;

    fifo_wr_arbiter #(.bw(4), .simd(1), .depth(depth), .max_burst(mb)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .fifo_wr(fifo_wr), .fifo_in(fifo_in), .fifo_full(fifo_full),
        .crd_ret(crd_ret), .grant_id(grant_id), .credits(credits), .crd_err(crd_err)
    );

    always #5 clk = ~clk;

    bit         m_busy, m_err, m_wr;
    int         m_gnt, m_last, m_beats, m_cred, m_beat_id;
    logic [3:0] m_in, prev_rdy;
    int         src_lim[4], src_cnt[4];
    logic [3:0] wr_log[$];
    int         gseq[$], bcnt[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_busy = 0; m_err = 0; m_wr = 0; m_in = '0;
        m_gnt = 0; m_last = 3; m_beats = 0; m_cred = depth; m_beat_id = -1;
        prev_rdy = '0;
    endtask

    // Burst-level view: who owns the port, how many words it has moved, how many slots are free.
    task automatic model_step(input logic [3:0] v, input logic [15:0] d, input logic c, input logic f);
        bit b;
        b = 0;
        m_beat_id = -1;
        if (!m_busy) begin
            m_wr = 0;
            for (int k = 1; k <= 4; k++)
                if (!m_busy && v[(m_last + k) % 4]) begin
                    m_busy = 1; m_gnt = (m_last + k) % 4; m_beats = 0;
                end
        end else begin
            b = v[m_gnt] && m_cred > 0 && !f;
            m_wr = b;
            if (b) begin m_in = d[m_gnt*4 +: 4]; m_beats++; m_beat_id = m_gnt; end
            if ((b && m_beats == mb) || !v[m_gnt]) begin m_busy = 0; m_last = m_gnt; end
        end
        if (c && !b && m_cred == depth) m_err = 1;
        else m_cred = m_cred + int'(c) - int'(b);
    endtask

    task automatic cyc(input logic [3:0] v, input logic [15:0] d, input logic c, input logic f);
        logic [3:0] er;
        @(negedge clk);
        chk("credits", 32'(credits), m_cred);
        chk("grant_id", 32'(grant_id), m_gnt);
        chk("fifo_wr", 32'(fifo_wr), 32'(m_wr));
        chk("fifo_in", 32'(fifo_in), 32'(m_in));
        chk("crd_err", 32'(crd_err), 32'(m_err));
        if (fifo_wr === 1'b1) wr_log.push_back(fifo_in);
        req_valid = v; req_data = d; crd_ret = c; fifo_full = f;
        #1;
        er = (m_busy && m_cred > 0 && !f) ? 4'(1 << m_gnt) : 4'b0000;
        chk("req_ready", 32'(req_ready), 32'(er));
        if (req_ready != 4'b0 && prev_rdy == 4'b0) begin gseq.push_back(int'(grant_id)); bcnt.push_back(0); end
        prev_rdy = req_ready;
        model_step(v, d, c, f);
        if (m_beat_id >= 0 && bcnt.size() > 0) bcnt[bcnt.size()-1] += 1;
    endtask

    task automatic src_cyc(input logic c, input logic f);
        logic [3:0]  v;
        logic [15:0] d;
        for (int i = 0; i < 4; i++) begin
            v[i] = src_lim[i] > 0;
            d[i*4 +: 4] = 4'(i * 4 + src_cnt[i]);
        end
        cyc(v, d, c, f);
        if (m_beat_id >= 0) begin src_cnt[m_beat_id]++; src_lim[m_beat_id]--; end
    endtask

    task automatic do_reset();
        rst_n = 0;
        #1;
        chk("rst_ready", 32'(req_ready), 0);
        chk("rst_fifo_wr", 32'(fifo_wr), 0);
        chk("rst_fifo_in", 32'(fifo_in), 0);
        chk("rst_credits", 32'(credits), depth);
        chk("rst_grant_id", 32'(grant_id), 0);
        chk("rst_crd_err", 32'(crd_err), 0);
        @(posedge clk);
        #1;
        rst_n = 1;
        model_reset();
        for (int i = 0; i < 4; i++) begin src_lim[i] = 0; src_cnt[i] = 0; end
        wr_log.delete(); gseq.delete(); bcnt.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int         bcyc[$];
        bit         added;
        logic [3:0] rv;
        #2;
        // single requester streams 8 words with no returns
        do_reset();
        src_lim[0] = 9;
        for (int i = 0; i < 12; i++) begin
            src_cyc(0, 0);
            if (m_beat_id >= 0) bcyc.push_back(i);
        end
        chk("t1_beats", bcyc.size(), 8);
        for (int k = 0; k < 8 && k < bcyc.size(); k++) chk("t1_beat_cycle", bcyc[k], k < 4 ? k + 1 : k + 2);
        chk("t1_credits", 32'(credits), 0);
        chk("t1_ready0", 32'(req_ready[0]), 0);
        chk("t1_words", wr_log.size(), 8);
        for (int k = 0; k < 8 && k < wr_log.size(); k++) chk("t1_word", 32'(wr_log[k]), k);
        // four-way contention with a return every cycle
        do_reset();
        for (int i = 0; i < 4; i++) src_lim[i] = 8;
        for (int i = 0; i < 26; i++) src_cyc(1, 0);
        chk("t2_grants", 32'(gseq.size() >= 5), 1);
        for (int k = 0; k < 5 && k < gseq.size(); k++) chk("t2_grant_id", gseq[k], k % 4);
        for (int k = 0; k < 4 && k < bcnt.size(); k++) chk("t2_burst_len", bcnt[k], 4);
        for (int k = 0; k < 16 && k < wr_log.size(); k++) chk("t2_order", 32'(wr_log[k]), k);
        // requester 2 stalled on zero credits, single return
        do_reset();
        src_lim[2] = 100;
        for (int i = 0; i < 15; i++) src_cyc(0, 0);
        chk("t3_cred0", 32'(credits), 0);
        chk("t3_stalled", 32'(req_ready), 0);
        src_cyc(1, 0);
        src_cyc(0, 0);
        chk("t3_cred1", 32'(credits), 1);
        chk("t3_ready", 32'(req_ready), 4);
        src_cyc(0, 0);
        chk("t3_cred_back0", 32'(credits), 0);
        chk("t3_one_beat", 32'(fifo_wr), 1);
        for (int i = 0; i < 3; i++) begin
            src_cyc(0, 0);
            chk("t3_no_beat", 32'(req_ready), 0);
        end
        src_cyc(1, 0);
        src_cyc(0, 0);
        chk("t3_still_burst", 32'(req_ready), 4);
        // simultaneous return and beat, then saturation
        do_reset();
        src_lim[1] = 100;
        for (int i = 0; i < 20 && m_cred != 3; i++) src_cyc(0, 0);
        chk("t4_at3", m_cred, 3);
        src_cyc(1, 0);
        chk("t4_beat_with_ret", 32'(m_beat_id), 1);
        src_lim[1] = 0;
        src_cyc(0, 0);
        chk("t4_cred_stay3", 32'(credits), 3);
        for (int i = 0; i < 5; i++) src_cyc(1, 0);
        src_cyc(1, 0);
        src_cyc(0, 0);
        chk("t4_cred_sat", 32'(credits), depth);
        chk("t4_err_set", 32'(crd_err), 1);
        for (int i = 0; i < 3; i++) src_cyc(0, 0);
        chk("t4_err_sticky", 32'(crd_err), 1);
        // requester 1 drops after two beats while 3 waits; 0 arrives later
        do_reset();
        src_lim[1] = 2; src_lim[3] = 4;
        added = 0;
        for (int i = 0; i < 16; i++) begin
            src_cyc(0, 0);
            if (!added && gseq.size() == 1) begin src_lim[0] = 2; added = 1; end
        end
        chk("t5_grants", 32'(gseq.size() >= 3), 1);
        if (gseq.size() >= 3) begin
            chk("t5_first", gseq[0], 1);
            chk("t5_after_drop", gseq[1], 3);
            chk("t5_then", gseq[2], 0);
        end
        // asynchronous reset mid-burst at credits 5
        do_reset();
        src_lim[1] = 1; src_lim[2] = 100;
        for (int i = 0; i < 20 && !(m_cred == 5 && m_busy); i++) src_cyc(0, 0);
        @(posedge clk);
        #2;
        chk("t6_pre_credits", 32'(credits), 5);
        chk("t6_pre_grant", 32'(grant_id), 2);
        do_reset();
        src_lim[0] = 4; src_lim[2] = 100;
        for (int i = 0; i < 4; i++) src_cyc(0, 0);
        chk("t6_first_winner", 32'(gseq.size() > 0 ? gseq[0] : -1), 0);
        // random traffic, returns and full-flag stalls
        do_reset();
        rv = '0;
        for (int i = 0; i < 600; i++) begin
            rv = ($urandom_range(0, 2) == 0) ? 4'($urandom) : rv;
            cyc(rv, 16'($urandom), $urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0);
            if (i == 300) do_reset();
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
